// File: rtl/tri_raster_pkg.sv
// Shared widths, state encoding, vertex/edge records and edge-function helpers
// for the tri_raster triangle rasterizer.
package tri_raster_pkg;
    localparam int TR_XW = 10;
    localparam int TR_YW = 9;
    localparam int TR_EW = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP0 = 3'd1,
        SETUP1 = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [TR_XW:0] x;
        logic signed [TR_YW:0] y;
    } vertex_t;

    typedef struct packed {
        logic signed [TR_EW-1:0] dex;
        logic signed [TR_EW-1:0] dey;
        logic signed [TR_EW-1:0] e;
        logic signed [TR_EW-1:0] row_e;
    } edge_t;

    function automatic logic signed [TR_EW-1:0] sext_x(input logic signed [TR_XW:0] v);
        return {{(TR_EW-TR_XW-1){v[TR_XW]}}, v};
    endfunction

    function automatic logic signed [TR_EW-1:0] sext_y(input logic signed [TR_YW:0] v);
        return {{(TR_EW-TR_YW-1){v[TR_YW]}}, v};
    endfunction

    // Edge function of the directed edge vi->vj evaluated at point p.
    function automatic logic signed [TR_EW-1:0] edge_at(
        input logic signed [TR_EW-1:0] px, py, xi, yi, xj, yj);
        return (px - xi) * (yj - yi) - (py - yi) * (xj - xi);
    endfunction

    // Inside test that accepts either winding; pixels on an edge count as inside.
    function automatic logic inside_tri(input logic signed [TR_EW-1:0] e0, e1, e2);
        logic all_ge;
        logic all_le;
        all_ge = !e0[TR_EW-1] && !e1[TR_EW-1] && !e2[TR_EW-1];
        all_le = (e0[TR_EW-1] || (e0 == '0)) && (e1[TR_EW-1] || (e1 == '0)) &&
                 (e2[TR_EW-1] || (e2 == '0));
        return all_ge || all_le;
    endfunction
endpackage

// File: rtl/tri_raster_edge_step.sv
// tri_edge_step: one edge-function accumulator with load, x-step and row-step.
module tri_edge_step
    import tri_raster_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step_x,
    input  logic                    step_y,
    input  logic signed [TR_EW-1:0] dex_in,
    input  logic signed [TR_EW-1:0] dey_in,
    input  logic signed [TR_EW-1:0] e_init,
    output logic signed [TR_EW-1:0] e_next
);
    edge_t edg_q;
    edge_t edg_d;

    // Next accumulator value; a row step restarts from the saved row-start value.
    always_comb begin
        edg_d = edg_q;
        if (load) begin
            edg_d.dex   = dex_in;
            edg_d.dey   = dey_in;
            edg_d.e     = e_init;
            edg_d.row_e = e_init;
        end else if (step_y) begin
            edg_d.e     = edg_q.row_e + edg_q.dey;
            edg_d.row_e = edg_q.row_e + edg_q.dey;
        end else if (step_x) begin
            edg_d.e     = edg_q.e + edg_q.dex;
        end else begin
            edg_d = edg_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            edg_q <= '0;
        end else begin
            edg_q <= edg_d;
        end
    end

    assign e_next = edg_d.e;
endmodule

// File: rtl/tri_raster.sv
// tri_raster: latches one triangle, sets up three edge functions and scans its
// bounding box row-major. Macro TRI_RASTER_BARY_EN adds weight and area outputs.
module tri_raster
    import tri_raster_pkg::*;
#(
    parameter int XW = TR_XW,
    parameter int YW = TR_YW,
    parameter int EW = TR_EW
) (
    input  logic          clk_pix,
    input  logic          reset,
    input  logic          start,
    input  logic [8:0]    ax,
    input  logic [6:0]    ay,
    input  logic [7:0]    abx,
    input  logic [7:0]    aby,
    input  logic [7:0]    acx,
    input  logic [7:0]    acy,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y
`ifdef TRI_RASTER_BARY_EN
    ,
    output logic [EW-1:0] out_w0,
    output logic [EW-1:0] out_w1,
    output logic [EW-1:0] out_w2,
    output logic [EW-1:0] out_area
`endif
);
    localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [47:0]        vin_q, vin_d;
    vertex_t            vb_q, vb_d, vc_q, vc_d;
    logic signed [XW:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [YW:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [XW-1:0]      cx_q, cx_d;
    logic [YW-1:0]      cy_q, cy_d;
    logic               busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;

    logic [8:0]         ax_l;
    logic [6:0]         ay_l;
    logic [7:0]         abx_l, aby_l, acx_l, acy_l;
    vertex_t            va_s, vb_s, vc_s;
    logic signed [XW:0] xlo_s, xhi_s;
    logic signed [YW:0] ylo_s, yhi_s;
    logic signed [EW-1:0] xa_e, ya_e, xb_e, yb_e, xc_e, yc_e, xmin_e, ymin_e;
    logic signed [EW-1:0] dex0_s, dey0_s, e0_init_s, dex1_s, dey1_s, e1_init_s;
    logic signed [EW-1:0] dex2_s, dey2_s, e2_init_s, area_s;
    logic signed [EW-1:0] e0_n, e1_n, e2_n;
    logic               load_s, step_x_s, step_y_s;

    assign {ax_l, ay_l, abx_l, aby_l, acx_l, acy_l} = vin_q;

    // Absolute vertices and bounding box, derived from the latched inputs.
    always_comb begin
        va_s.x = {{(XW-8){1'b0}}, ax_l};
        va_s.y = {{(YW-6){1'b0}}, ay_l};
        vb_s.x = va_s.x + {{(XW-7){abx_l[7]}}, abx_l};
        vb_s.y = {{(YW-7){1'b0}}, aby_l};
        vc_s.x = va_s.x + {{(XW-7){acx_l[7]}}, acx_l};
        vc_s.y = {{(YW-7){1'b0}}, acy_l};
        xlo_s = ($signed(vb_s.x) < $signed(va_s.x)) ? vb_s.x : va_s.x;
        xlo_s = ($signed(vc_s.x) < xlo_s) ? vc_s.x : xlo_s;
        xhi_s = ($signed(vb_s.x) > $signed(va_s.x)) ? vb_s.x : va_s.x;
        xhi_s = ($signed(vc_s.x) > xhi_s) ? vc_s.x : xhi_s;
        ylo_s = ($signed(vb_s.y) < $signed(va_s.y)) ? vb_s.y : va_s.y;
        ylo_s = ($signed(vc_s.y) < ylo_s) ? vc_s.y : ylo_s;
        yhi_s = ($signed(vb_s.y) > $signed(va_s.y)) ? vb_s.y : va_s.y;
        yhi_s = ($signed(vc_s.y) > yhi_s) ? vc_s.y : yhi_s;
    end

    // Edge setup: AB, BC, CA deltas and values at the box origin, plus area.
    always_comb begin
        xa_e      = sext_x(va_s.x);
        ya_e      = sext_y(va_s.y);
        xb_e      = sext_x(vb_q.x);
        yb_e      = sext_y(vb_q.y);
        xc_e      = sext_x(vc_q.x);
        yc_e      = sext_y(vc_q.y);
        xmin_e    = sext_x(xmin_q);
        ymin_e    = sext_y(ymin_q);
        dex0_s    = yb_e - ya_e;
        dey0_s    = xa_e - xb_e;
        e0_init_s = edge_at(xmin_e, ymin_e, xa_e, ya_e, xb_e, yb_e);
        dex1_s    = yc_e - yb_e;
        dey1_s    = xb_e - xc_e;
        e1_init_s = edge_at(xmin_e, ymin_e, xb_e, yb_e, xc_e, yc_e);
        dex2_s    = ya_e - yc_e;
        dey2_s    = xc_e - xa_e;
        e2_init_s = edge_at(xmin_e, ymin_e, xc_e, yc_e, xa_e, ya_e);
        area_s    = edge_at(xc_e, yc_e, xa_e, ya_e, xb_e, yb_e);
    end

    tri_edge_step u_edge_ab (
        .clk(clk_pix), .reset(reset), .load(load_s), .step_x(step_x_s), .step_y(step_y_s),
        .dex_in(dex0_s), .dey_in(dey0_s), .e_init(e0_init_s), .e_next(e0_n)
    );
    tri_edge_step u_edge_bc (
        .clk(clk_pix), .reset(reset), .load(load_s), .step_x(step_x_s), .step_y(step_y_s),
        .dex_in(dex1_s), .dey_in(dey1_s), .e_init(e1_init_s), .e_next(e1_n)
    );
    tri_edge_step u_edge_ca (
        .clk(clk_pix), .reset(reset), .load(load_s), .step_x(step_x_s), .step_y(step_y_s),
        .dex_in(dex2_s), .dey_in(dey2_s), .e_init(e2_init_s), .e_next(e2_n)
    );

    // Sequencer next-state; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d  = state_q;
        vin_d    = vin_q;
        vb_d     = vb_q;
        vc_d     = vc_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        load_s   = 1'b0;
        step_x_s = 1'b0;
        step_y_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vin_d   = {ax, ay, abx, aby, acx, acy};
                    state_d = SETUP0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP0: begin
                vb_d    = vb_s;
                vc_d    = vc_s;
                xmin_d  = xlo_s;
                xmax_d  = xhi_s;
                ymin_d  = ylo_s;
                ymax_d  = yhi_s;
                state_d = SETUP1;
            end
            SETUP1: begin
                load_s  = 1'b1;
                cx_d    = xmin_q[XW-1:0];
                cy_d    = ymin_q[YW-1:0];
                state_d = (area_s == '0) ? DONE : SCAN;
            end
            SCAN: begin
                if (out_valid_q && !out_ready) begin
                    state_d = SCAN;
                end else if ({1'b0, cx_q} == xmax_q) begin
                    if ({1'b0, cy_q} == ymax_q) begin
                        state_d = DONE;
                    end else begin
                        cx_d     = xmin_q[XW-1:0];
                        cy_d     = cy_q + Y_ONE;
                        step_y_s = 1'b1;
                    end
                end else begin
                    cx_d     = cx_q + X_ONE;
                    step_x_s = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d == SETUP0) || (state_d == SETUP1) || (state_d == SCAN);
        done_d      = (state_d == DONE);
        out_valid_d = (state_d == SCAN) && inside_tri(e0_n, e1_n, e2_n);
    end

    // State and datapath registers.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_q     <= IDLE;
            vin_q       <= '0;
            vb_q        <= '0;
            vc_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vin_q       <= vin_d;
            vb_q        <= vb_d;
            vc_q        <= vc_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_x     = cx_q;
    assign out_y     = cy_q;

`ifdef TRI_RASTER_BARY_EN
    logic signed [EW-1:0] area_q, area_d;
    logic [EW-1:0]        area_abs_q, area_abs_d;
    logic [EW-1:0]        w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;

    // Weights follow the pixel being presented, flipped so they are non-negative.
    always_comb begin
        area_d     = (state_q == SETUP1) ? area_s : area_q;
        area_abs_d = area_d[EW-1] ? -area_d : area_d;
        w0_d       = area_d[EW-1] ? -e0_n : e0_n;
        w1_d       = area_d[EW-1] ? -e1_n : e1_n;
        w2_d       = area_d[EW-1] ? -e2_n : e2_n;
    end

    // Weight and area registers.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            area_q     <= '0;
            area_abs_q <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
        end else begin
            area_q     <= area_d;
            area_abs_q <= area_abs_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
        end
    end

    assign out_w0   = w0_q;
    assign out_w1   = w1_q;
    assign out_w2   = w2_q;
    assign out_area = area_abs_q;
`endif
endmodule

// File: tb/tb_tri_raster.sv
// Bench for tri_raster: fixed and random triangles with random backpressure,
// checked against a direct per-pixel edge-function model.
module tb_tri_raster;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int EW = 24;

    logic          clk_pix = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [8:0]    ax = '0;
    logic [6:0]    ay = '0;
    logic [7:0]    abx = '0, aby = '0, acx = '0, acy = '0;
    logic          busy, done, out_valid;
    logic          out_ready = 1'b1;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
`ifdef TRI_RASTER_BARY_EN
    logic [EW-1:0] out_w0, out_w1, out_w2, out_area;
`endif

    always #5 clk_pix = ~clk_pix;

    tri_raster dut (
        .clk_pix(clk_pix), .reset(reset), .start(start),
        .ax(ax), .ay(ay), .abx(abx), .aby(aby), .acx(acx), .acy(acy),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y)
`ifdef TRI_RASTER_BARY_EN
        , .out_w0(out_w0), .out_w1(out_w1), .out_w2(out_w2), .out_area(out_area)
`endif
    );

    int total = 0;
    int bad = 0;
    int exp_x[$], exp_y[$], exp_w0[$], exp_w1[$], exp_w2[$];
    int got_x[$], got_y[$], got_w0[$], got_w1[$], got_w2[$];
    int exp_area, exp_scan, got_area, done_cyc, stall_err;

    // Reference: evaluate every bounding-box pixel directly, row-major.
    task automatic model(input int ax_i, ay_i, abx_i, aby_i, acx_i, acy_i);
        int xa, ya, xb, yb, xc, yc, area, xmin, xmax, ymin, ymax, e0, e1, e2;
        exp_x.delete(); exp_y.delete(); exp_w0.delete(); exp_w1.delete(); exp_w2.delete();
        xa = ax_i; ya = ay_i; xb = ax_i + abx_i; yb = aby_i; xc = ax_i + acx_i; yc = acy_i;
        area = (xc - xa) * (yb - ya) - (yc - ya) * (xb - xa);
        xmin = (xa < xb) ? xa : xb; xmin = (xc < xmin) ? xc : xmin;
        xmax = (xa > xb) ? xa : xb; xmax = (xc > xmax) ? xc : xmax;
        ymin = (ya < yb) ? ya : yb; ymin = (yc < ymin) ? yc : ymin;
        ymax = (ya > yb) ? ya : yb; ymax = (yc > ymax) ? yc : ymax;
        exp_area = (area < 0) ? -area : area;
        exp_scan = (area == 0) ? 0 : (xmax - xmin + 1) * (ymax - ymin + 1);
        if (area != 0) begin
            for (int y = ymin; y <= ymax; y++) begin
                for (int x = xmin; x <= xmax; x++) begin
                    e0 = (x - xa) * (yb - ya) - (y - ya) * (xb - xa);
                    e1 = (x - xb) * (yc - yb) - (y - yb) * (xc - xb);
                    e2 = (x - xc) * (ya - yc) - (y - yc) * (xa - xc);
                    if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
                        exp_x.push_back(x); exp_y.push_back(y);
                        exp_w0.push_back(area < 0 ? -e0 : e0);
                        exp_w1.push_back(area < 0 ? -e1 : e1);
                        exp_w2.push_back(area < 0 ? -e2 : e2);
                    end
                end
            end
        end
    endtask

    // Basic triangle from the plan, written out row by row.
    task automatic build_basic();
        exp_x.delete(); exp_y.delete();
        for (int r = 0; r < 5; r++) begin
            for (int x = 320 - r; x <= 320 + r; x++) begin
                exp_x.push_back(x); exp_y.push_back(120 + r);
            end
        end
    endtask

    // Start one triangle and collect accepted pixels until done (bounded).
    task automatic run_tri(input int ax_i, ay_i, abx_i, aby_i, acx_i, acy_i,
                           input int ready_pct, input int inject, input int max_cyc);
        logic stalled;
        int px, py;
        got_x.delete(); got_y.delete(); got_w0.delete(); got_w1.delete(); got_w2.delete();
        done_cyc = -1; stall_err = 0; stalled = 1'b0; got_area = -1; px = 0; py = 0;
        ax = ax_i[8:0]; ay = ay_i[6:0]; abx = abx_i[7:0]; aby = aby_i[7:0];
        acx = acx_i[7:0]; acy = acy_i[7:0];
        start = 1'b1;
        @(posedge clk_pix); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            start = (cyc == inject);
            if (cyc == inject) begin
                ax = 9'($urandom_range(511)); ay = 7'($urandom_range(127));
                abx = 8'($urandom_range(255)); aby = 8'($urandom_range(255));
                acx = 8'($urandom_range(255)); acy = 8'($urandom_range(255));
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (stalled && (!out_valid || int'(out_x) != px || int'(out_y) != py)) stall_err++;
            if (out_valid) begin
                if (out_ready) begin
                    got_x.push_back(int'(out_x)); got_y.push_back(int'(out_y));
`ifdef TRI_RASTER_BARY_EN
                    got_w0.push_back(int'(out_w0)); got_w1.push_back(int'(out_w1));
                    got_w2.push_back(int'(out_w2));
`endif
                end
                px = int'(out_x); py = int'(out_y);
            end
            stalled = out_valid && !out_ready;
            if (done) begin
                done_cyc = cyc;
`ifdef TRI_RASTER_BARY_EN
                got_area = int'(out_area);
`endif
                break;
            end
            @(posedge clk_pix); #1;
        end
        @(posedge clk_pix); #1;
        start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_pix);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_x !== '0) begin bad++; $display("FAIL reset_x got=%0d exp=0", out_x); end
        total++; if (out_y !== '0) begin bad++; $display("FAIL reset_y got=%0d exp=0", out_y); end
        reset = 1'b0;
        @(posedge clk_pix); #1;
    endtask

    task automatic test_degenerate();
        run_tri(320, 120, 0, 180, 0, 200, 100, -1, 100);
        total++; if (got_x.size() != 0) begin bad++; $display("FAIL degen_count got=%0d exp=0", got_x.size()); end
        total++; if (done_cyc != 3) begin bad++; $display("FAIL degen_done_cycle got=%0d exp=3", done_cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL degen_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        run_tri(320, 120, -4, 124, 4, 124, 100, -1, 200);
        build_basic();
        total++; if (got_x.size() != 25) begin bad++; $display("FAIL basic_count got=%0d exp=25", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            total++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                bad++; $display("FAIL basic_pix[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
        total++; if (done_cyc != 48) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=48", done_cyc); end
    endtask

    task automatic test_backpressure();
        model(320, 120, -4, 124, 4, 124);
        run_tri(320, 120, -4, 124, 4, 124, 45, -1, 2000);
        total++; if (got_x.size() != exp_x.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_x.size(), exp_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            total++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                bad++; $display("FAIL bp_pix[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
        total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
        total++; if (done_cyc < 48) begin bad++; $display("FAIL bp_done got=%0d exp>=48", done_cyc); end
    endtask

    task automatic test_reverse();
        build_basic();
        run_tri(320, 120, 4, 124, -4, 124, 100, -1, 200);
        total++; if (got_x.size() != 25) begin bad++; $display("FAIL rev_count got=%0d exp=25", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            total++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                bad++; $display("FAIL rev_pix[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
`ifdef TRI_RASTER_BARY_EN
        total++; if (got_area != 32) begin bad++; $display("FAIL rev_area got=%0d exp=32", got_area); end
`endif
    endtask

    task automatic test_reset_mid();
        ax = 9'd320; ay = 7'd120; abx = 8'hFC; aby = 8'd124; acx = 8'd4; acy = 8'd124;
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk_pix); #1;
        start = 1'b0;
        repeat (12) @(posedge clk_pix);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        @(posedge clk_pix); #1;
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done); end
        build_basic();
        run_tri(320, 120, -4, 124, 4, 124, 100, -1, 200);
        total++; if (got_x.size() != 25) begin bad++; $display("FAIL mid_rerun_count got=%0d exp=25", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            total++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                bad++; $display("FAIL mid_pix[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        build_basic();
        run_tri(320, 120, -4, 124, 4, 124, 100, 6, 200);
        total++; if (got_x.size() != 25) begin bad++; $display("FAIL sbusy_count got=%0d exp=25", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            total++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                bad++; $display("FAIL sbusy_pix[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
        total++; if (done_cyc != 48) begin bad++; $display("FAIL sbusy_done_cycle got=%0d exp=48", done_cyc); end
        run_tri(320, 120, -4, 124, 4, 124, 100, 48, 200);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sdone_ignored got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        int a_x, a_y, b_dx, b_y, c_dx, c_y, pct;
        for (int t = 0; t < 8; t++) begin
            a_x = 40 + int'($urandom_range(400)); a_y = int'($urandom_range(127));
            b_dx = int'($urandom_range(40)) - 20; c_dx = int'($urandom_range(40)) - 20;
            b_y = a_y + int'($urandom_range(40)) - 20; b_y = (b_y < 0) ? 0 : b_y;
            c_y = a_y + int'($urandom_range(40)) - 20; c_y = (c_y < 0) ? 0 : c_y;
            pct = (t < 2) ? 100 : 60;
            model(a_x, a_y, b_dx, b_y, c_dx, c_y);
            run_tri(a_x, a_y, b_dx, b_y, c_dx, c_y, pct, -1, 20000);
            total++; if (got_x.size() != exp_x.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", t, got_x.size(), exp_x.size()); end
            for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
                total++;
                if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                    bad++; $display("FAIL rnd%0d_pix[%0d] got=(%0d,%0d) exp=(%0d,%0d)", t, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
                end
`ifdef TRI_RASTER_BARY_EN
                total++;
                if (got_w0[i] != exp_w0[i] || got_w1[i] != exp_w1[i] || got_w2[i] != exp_w2[i]) begin
                    bad++; $display("FAIL rnd%0d_w[%0d] got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", t, i, got_w0[i], got_w1[i], got_w2[i], exp_w0[i], exp_w1[i], exp_w2[i]);
                end
`endif
            end
            total++; if (stall_err != 0) begin bad++; $display("FAIL rnd%0d_stall got=%0d exp=0", t, stall_err); end
            if (pct == 100) begin
                total++; if (done_cyc != 3 + exp_scan) begin bad++; $display("FAIL rnd%0d_done_cycle got=%0d exp=%0d", t, done_cyc, 3 + exp_scan); end
            end else begin
                total++; if (done_cyc < 3 + exp_scan) begin bad++; $display("FAIL rnd%0d_done got=%0d exp>=%0d", t, done_cyc, 3 + exp_scan); end
            end
        end
    endtask

`ifdef TRI_RASTER_BARY_EN
    task automatic test_bary();
        run_tri(320, 120, -4, 124, 4, 124, 70, -1, 2000);
        total++; if (got_area != 32) begin bad++; $display("FAIL bary_area got=%0d exp=32", got_area); end
        total++;
        if (got_x.size() == 0 || got_x[0] != 320 || got_y[0] != 120 || got_w2[0] != 0) begin
            bad++; $display("FAIL bary_wca_apex got=%0d exp=0", (got_w2.size() > 0) ? got_w2[0] : -1);
        end
        for (int i = 0; i < got_x.size(); i++) begin
            total++;
            if (got_w0[i] + got_w1[i] + got_w2[i] != 32) begin
                bad++; $display("FAIL bary_sum[%0d] got=%0d exp=32", i, got_w0[i] + got_w1[i] + got_w2[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_degenerate();
        test_basic();
        test_backpressure();
        test_reverse();
        test_reset_mid();
        test_start_busy();
        test_random();
`ifdef TRI_RASTER_BARY_EN
        test_bary();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tri_raster.md
Name: tri_raster

Overview:
Triangle rasterizer directly downstream of the vertex shader.
- On a frame-start pulse it latches one triangle: vertex A absolute, vertex B/C as signed x offset plus absolute y.
- Runs a two-cycle setup, then scans the bounding box row-major with incremental edge functions.
- Emits covered pixel coordinates over a valid/ready stream to the fragment/framebuffer stage.

Parameters:
XW, 10, pixel x width (640-wide screen)
YW, 9, pixel y width
EW, 24, signed edge-function accumulator width

Ports:
clk_pix  in  1  pixel clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: latch vertex inputs, begin triangle
ax  in  9  vertex A x, unsigned
ay  in  7  vertex A y, unsigned
abx  in  8  signed x offset of B from A
aby  in  8  vertex B y, unsigned absolute
acx  in  8  signed x offset of C from A
acy  in  8  vertex C y, unsigned absolute
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse, triangle finished
out_valid  out  1  pixel available
out_ready  in  1  downstream accepts pixel
out_x  out  XW  pixel x
out_y  out  YW  pixel y

Behaviour:
- Reset: state IDLE. busy, done, out_valid = 0. out_x, out_y = 0. All internal registers = 0.
- Vertex expansion:
  - A = (ax, ay).
  - B = (ax + sext(abx), aby); C = (ax + sext(acx), acy).
  - Computed at XW/YW+1 signed width; the shader's ranges never go negative.
- States: IDLE -> SETUP0 -> SETUP1 -> SCAN -> DONE -> IDLE.
- IDLE: start latches all inputs, busy=1, go to SETUP0. start in any other state is ignored.
- SETUP0: register B and C absolute coordinates and the bounding box (min/max of x, min/max of y).
- SETUP1, per edge i (AB, BC, CA), with vi -> vj:
  - dEx_i = yj - yi; dEy_i = -(xj - xi).
  - E_i = (xmin - xi)*dEx_i + (ymin - yi)*dEy_i, sign-extended to EW.
  - area = E_AB evaluated at C.
  - If area == 0 (degenerate), go to DONE and emit no pixels.
- SCAN, one evaluation per cycle at (cx, cy):
  - Covered iff all three E >= 0, or all three E <= 0. This accepts both windings, since the winding flips as the shader rotates. Boundary pixels (E=0) are covered.
  - Covered pixel: out_valid=1, out_x=cx, out_y=cy. Hold all of these stable while out_ready=0. Advance on the cycle out_valid && out_ready.
  - Uncovered pixel: advance the same cycle, out_valid=0.
  - Advance within a row: cx+1, E_i += dEx_i.
  - Advance at cx==xmax: cx=xmin, cy+1, E_i = rowE_i + dEy_i, and rowE_i updates to that value.
  - Advancing past (xmax, ymax) goes to DONE.
- Latency: first bounding-box evaluation is 3 cycles after the start cycle. Throughput is 1 pixel/cycle with no backpressure.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- Reset mid-operation: next cycle state IDLE, out_valid/busy/done = 0. A pending pixel is discarded.
- Pixel order is strictly row-major, each covered pixel exactly once.

Optional Feature:
TRI_RASTER_BARY_EN
- Defined: adds outputs out_w0, out_w1, out_w2 (EW each). These are the E_AB, E_BC, E_CA values of the emitted pixel, held with out_x/out_y under backpressure and negated when area < 0 so they are always >= 0. Also adds output out_area (EW) = |area|, stable while busy.
- Undefined: no extra ports or logic.

Decomposition:
- Package tri_raster_pkg: XW/YW/EW defaults, state enum (IDLE, SETUP0, SETUP1, SCAN, DONE), vertex struct {x, y}, edge struct {dEx, dEy, e, rowE}.
- One natural sub-module, tri_edge_step: one edge's accumulator. It takes init/load, x-step, row-step and hold controls and exposes E. Instantiate it three times.

Test Plan:
- Degenerate: start with ax=320, ay=120, abx=0, aby=180, acx=0, acy=200 -> zero pixels, done 3 cycles after start, busy low after.
- Basic: ax=320, ay=120, abx=-4, aby=124, acx=4, acy=124, out_ready=1 -> exactly 25 pixels, row-major, in rows of 1, 3, 5, 7, 9:
  - y=120: x=320
  - y=121: x=319..321
  - y=122: x=318..322
  - y=123: x=317..323
  - y=124: x=316..324
  - done after 45 scan cycles.
- Backpressure: same triangle with random out_ready -> identical 25-pixel sequence, no drops or duplicates, out_x/out_y stable while stalled.
- Reverse winding: abx=4, acx=-4 (same y's) -> same 25 pixels.
- Reset/start robustness:
  - reset asserted mid-SCAN -> next cycle out_valid=0, busy=0. A fresh start then yields the full 25 pixels.
  - start pulsed while busy -> ignored.
- TRI_RASTER_BARY_EN, basic triangle:
  - out_area=32.
  - pixel (320,120) has w_CA=0.
  - every emitted pixel has w0+w1+w2 == out_area.
